// File: rtl/clock_disp_pkg.sv
// Shared clock-display types: converter FSM states, BCD blank code, decimal limit helper.
package clock_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [31:0] dec_max(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bundle between a binary producer and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// One BCD digit correction step of shift-and-add-3 (purely combinational).
module bcd_add3_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? (d + 4'd3) : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD: WIDTH shift cycles after accept, result held in DONE until out_ready.
// BIN_TO_BCD_BLANK_EN enables leading-zero blanking of the presented digits.
module bin_to_bcd_seq
  import clock_disp_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input logic             clk,
  input logic             rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 17) ? WIDTH : 17;
  localparam int NW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MAX_VAL = CW'(dec_max(DIGITS));

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] SHIFT = 2'(ST_SHIFT);
  localparam logic [1:0] DONE  = 2'(ST_DONE);

  logic [1:0]       state;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    corr;
  logic [BW-1:0]    bcd_shifted;
  logic [BW-1:0]    fmt;
  logic [BW-1:0]    out_bcd_q;
  logic [NW-1:0]    cnt;
  logic             ovf;
  logic             out_ovf_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .d (bcd[4*g +: 4]),
      .q (corr[4*g +: 4])
    );
  end

  assign bcd_shifted = {corr[BW-2:0], bin[WIDTH-1]};

  // Presentation value is built from the final shift so it can be registered on entry to DONE.
  always_comb begin
    fmt = bcd_shifted;
`ifdef BIN_TO_BCD_BLANK_EN
    begin : blank
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (bcd_shifted[4*i +: 4] == 4'd0)) begin
          fmt[4*i +: 4] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    if (ovf) begin
      fmt = {DIGITS{4'h9}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin   <= bus.in_data;
            bcd   <= '0;
            cnt   <= NW'(WIDTH);
            ovf   <= CW'(bus.in_data) > MAX_VAL;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= bcd_shifted;
          bin <= bin << 1;
          cnt <= cnt - NW'(1);
          if (cnt == NW'(1)) begin
            state     <= DONE;
            out_bcd_q <= fmt;
            out_ovf_q <= ovf;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_bcd   = out_bcd_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised, sequential binary-to-BCD converter for the clock display path. It accepts a `WIDTH`-bit unsigned binary value over a valid/ready handshake and converts it with iterative shift-and-add-3, one input bit per cycle. It then presents `DIGITS` packed BCD digits with overflow saturation until the output is consumed. It sits between the time counters and the 7-segment digit drivers, and it replaces fixed two-digit combinational splitting for arbitrary counter widths.

## Interface
Parameters:
- `WIDTH`, default 6: input binary width; valid range 1–16.
- `DIGITS`, default 2: number of BCD output digits; valid range 1–5.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block can accept; high only in IDLE.
- `in_data`, in, `WIDTH`: unsigned binary value.
- `out_valid`, out, 1: result is valid; held until taken.
- `out_ready`, in, 1: downstream takes the result.
- `out_bcd`, out, `4*DIGITS`: packed digits; digit 0 (units) is in `[3:0]`.
- `out_ovf`, out, 1: input exceeded `10^DIGITS-1`; qualified by `out_valid`.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready=1`.
  - Accept when `in_valid && in_ready` at a rising edge.
  - On accept, load the binary shift register with `in_data` and clear the BCD register.
  - On accept, load the bit counter with `WIDTH`.
  - On accept, latch `ovf = (in_data > 10^DIGITS-1)` and go to SHIFT.
- SHIFT, each cycle:
  - For every digit >= 5, add 3 to that digit.
  - Then shift `{bcd, bin}` left by one.
  - Decrement the counter. When the counter goes 1 -> 0, go to DONE.
- DONE:
  - `out_valid=1`.
  - `out_bcd` is the converted value, or all digits 4'h9 if `ovf`.
  - `out_ovf=ovf`.
  - On `out_valid && out_ready`, return to IDLE.
- Arithmetic rules:
  - Digit add-3 is 4-bit modulo with no carry into the neighbouring digit; the algorithm guarantees none occurs.
  - Bits shifted out of the top digit are discarded; the overflow flag covers that case.
- `10^DIGITS-1` is a localparam computed at elaboration. Its comparison width is `max(WIDTH, 17)` bits so that `DIGITS=5` does not truncate.
- Inputs are ignored outside IDLE: `in_data` changes during SHIFT or DONE have no effect.
- `out_bcd` and `out_ovf` are stable for the whole of DONE.
- Outside DONE they hold their last value. They are don't-care for the consumer, but the bench checks they do not toggle while `out_valid=1`.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `out_bcd=0`, `out_ovf=0`, counter 0.
- Latency: accept at edge E; `out_valid` rises after edge E+`WIDTH` (exactly `WIDTH` SHIFT cycles).
- Throughput: one conversion per `WIDTH+2` cycles when `out_ready` is tied high. The DONE cycle and the IDLE cycle are not overlapped.
- `out_ready` may be high before `out_valid`; the transfer occurs in the first DONE cycle.
- Reset mid-SHIFT or mid-DONE aborts immediately with no output.
- `out_valid` falls asynchronously with `rst_n` low.

## Configuration
- `BIN_TO_BCD_BLANK_EN` defined: leading-zero blanking is applied in DONE.
  - Every digit above the most significant non-zero digit outputs 4'hF (the blank code for the segment driver).
  - Digit 0 is never blanked, so value 0 shows as a single 0.
  - Saturated overflow output (all 9s) is never blanked.
- Not defined: all digits are output as plain BCD with leading zeros.

## Structure
- A shared package `clock_disp_pkg` holds:
  - the FSM state enum (IDLE/SHIFT/DONE);
  - the `BCD_BLANK = 4'hF` constant;
  - a function returning `10^n-1`.
- One sub-module is natural: `bcd_add3_digit`, a combinational digit correction (`d >= 5 ? d+3 : d`). It is instantiated `DIGITS` times in a generate loop.
- Blanking and saturation muxing live in the top module.

## Test plan
- Defaults (6/2), `in_data=59`, `out_ready=1`:
  - `out_valid` exactly 6 cycles after accept;
  - `out_bcd=8'h59`, `out_ovf=0`.
- Defaults, `in_data=0`, then 63 back-to-back:
  - results `8'h00` and `8'h63`;
  - `in_ready` low for 7 cycles per conversion.
- `DIGITS=1`, `in_data=10`: `out_bcd=4'h9`, `out_ovf=1`.
- Backpressure: `in_data=42` with `out_ready=0` for 5 DONE cycles:
  - `out_valid` and `8'h42` held stable;
  - `in_ready=0` throughout;
  - a new `in_valid` is ignored until the transfer.
- Reset pulse 3 cycles into SHIFT:
  - all outputs at reset values;
  - the next accepted 17 yields `8'h17`.
- `BIN_TO_BCD_BLANK_EN`, `WIDTH=10`, `DIGITS=3`:
  - `in_data=7` yields `12'hFF7`;
  - `in_data=0` yields `12'hFF0`;
  - `in_data=1000` yields `12'h999` with `out_ovf=1`.
